// File: rtl/instr_fetch.sv
// Fetch stage between pc_unit and the decoder: reads an opcode word and an optional
// immediate word, steers pc_unit, and hands one instruction at a time to the decoder.
module instr_fetch #(
  parameter int IMM_BIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] pc,
  output logic [1:0]  pc_op,
  output logic [15:0] pc_target,
  input  logic        flush,
  input  logic [15:0] flush_addr,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instr_word,
  output logic [15:0] imm_word,
  output logic        has_imm
);

  // pc_unit operation encodings shared with cpu_constants.vh
  localparam logic [1:0] PC_NOP   = 2'd0;
  localparam logic [1:0] PC_INC   = 2'd1;
  localparam logic [1:0] PC_SET   = 2'd2;
  localparam logic [1:0] PC_RESET = 2'd3;

  typedef enum logic [1:0] {
    S_RESET,
    S_FETCH_OP,
    S_FETCH_IMM,
    S_HOLD
  } state_t;

  state_t      r_state;
  logic        r_instr_valid;
  logic [15:0] r_instr_word;
  logic [15:0] r_imm_word;
  logic        r_has_imm;

  logic w_in_reset;
  logic w_flushing;
  logic w_active;
  logic w_fetching;
  logic w_ack_taken;
  logic w_handshake;

  // Flush outranks the stall; a stalled or flushing cycle never consumes an ack.
  assign w_in_reset  = !rst_n || (r_state == S_RESET);
  assign w_flushing  = !w_in_reset && flush;
  assign w_active    = !w_in_reset && !flush && en;
  assign w_fetching  = (r_state == S_FETCH_OP) || (r_state == S_FETCH_IMM);
  assign w_ack_taken = w_active && w_fetching && mem_ack;
  assign w_handshake = w_active && (r_state == S_HOLD) && r_instr_valid && instr_ready;

  always_comb begin
    pc_op = PC_NOP;
    if (w_in_reset) begin
      pc_op = PC_RESET;
    end else if (w_flushing) begin
      pc_op = PC_SET;
    end else if (w_ack_taken) begin
      pc_op = PC_INC;
    end
  end

  assign pc_target   = w_flushing ? flush_addr : 16'h0000;
  assign mem_req     = w_active && w_fetching;
  assign mem_addr    = mem_req ? pc : 16'h0000;
  assign instr_valid = r_instr_valid && !w_flushing;
  assign instr_word  = r_instr_word;
  assign imm_word    = r_imm_word;
  assign has_imm     = r_has_imm;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_RESET;
      r_instr_valid <= 1'b0;
      r_instr_word  <= 16'h0000;
      r_imm_word    <= 16'h0000;
      r_has_imm     <= 1'b0;
    end else if (r_state == S_RESET) begin
      r_state <= S_FETCH_OP;
    end else if (flush) begin
      // Whatever was partially fetched or held is dropped; refetch at the new PC.
      r_state       <= S_FETCH_OP;
      r_instr_valid <= 1'b0;
    end else if (en) begin
      case (r_state)
        S_FETCH_OP: begin
          if (mem_ack) begin
            r_instr_word <= mem_data;
            r_has_imm    <= mem_data[IMM_BIT];
            if (mem_data[IMM_BIT]) begin
              r_state <= S_FETCH_IMM;
            end else begin
              r_imm_word    <= 16'h0000;
              r_instr_valid <= 1'b1;
              r_state       <= S_HOLD;
            end
          end
        end
        S_FETCH_IMM: begin
          if (mem_ack) begin
            r_imm_word    <= mem_data;
            r_instr_valid <= 1'b1;
            r_state       <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (w_handshake) begin
            r_instr_valid <= 1'b0;
            r_state       <= S_FETCH_OP;
          end
        end
        default: r_state <= S_FETCH_OP;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: directed scenarios followed by a randomized run checked
// against an instruction-stream model of program memory.
module tb_instr_fetch;

  localparam logic [1:0] PC_NOP   = 2'd0;
  localparam logic [1:0] PC_INC   = 2'd1;
  localparam logic [1:0] PC_SET   = 2'd2;
  localparam logic [1:0] PC_RESET = 2'd3;

  logic        clk = 1'b0;
  logic        rstN;
  logic        en;
  logic [15:0] pcReg;
  logic [1:0]  pcOp;
  logic [15:0] pcTarget;
  logic        flush;
  logic [15:0] flushAddr;
  logic        memReq;
  logic [15:0] memAddr;
  logic        memAck;
  logic [15:0] memData;
  logic        instrValid;
  logic        instrReady;
  logic [15:0] instrWord;
  logic [15:0] immWord;
  logic        hasImm;

  logic [15:0] memArr [0:32767];

  int testsRun = 0;
  int failCount = 0;

  instr_fetch #(.IMM_BIT(8)) dut (
    .clk        (clk),
    .rst_n      (rstN),
    .en         (en),
    .pc         (pcReg),
    .pc_op      (pcOp),
    .pc_target  (pcTarget),
    .flush      (flush),
    .flush_addr (flushAddr),
    .mem_req    (memReq),
    .mem_addr   (memAddr),
    .mem_ack    (memAck),
    .mem_data   (memData),
    .instr_valid(instrValid),
    .instr_ready(instrReady),
    .instr_word (instrWord),
    .imm_word   (immWord),
    .has_imm    (hasImm)
  );

  always #5 clk = ~clk;

  // Stand-in for pc_unit, obeying whatever operation the fetch stage requests.
  always @(posedge clk) begin
    case (pcOp)
      PC_RESET: pcReg <= 16'h0000;
      PC_INC:   pcReg <= pcReg + 16'd2;
      PC_SET:   pcReg <= pcTarget;
      default:  pcReg <= pcReg;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives the inputs, lets the combinational outputs settle, then returns
  // the memory word at the current request address on mem_data.
  task automatic applyStimulus(input logic enV, input logic flushV, input logic [15:0] flushA,
                               input logic ackV, input logic readyV);
    en         = enV;
    flush      = flushV;
    flushAddr  = flushA;
    instrReady = readyV;
    memAck     = ackV;
    #1;
    memData = memArr[memAddr[15:1]];
    #1;
  endtask

  initial begin
    logic [15:0] expAddr;
    logic [15:0] op;
    int accepted;

    for (int i = 0; i < 32768; i++) memArr[i] = 16'($urandom);

    rstN = 1'b0; en = 1'b1; flush = 1'b0; flushAddr = 16'h0; memAck = 1'b0;
    memData = 16'h0; instrReady = 1'b0;

    // Reset held for two cycles
    tick(); tick();
    checkOutput("reset_pc_op", 16'(pcOp), 16'(PC_RESET));
    checkOutput("reset_valid", 16'(instrValid), 16'd0);
    checkOutput("reset_mem_req", 16'(memReq), 16'd0);
    rstN = 1'b1;
    tick();
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    checkOutput("post_reset_mem_req", 16'(memReq), 16'd1);
    checkOutput("post_reset_mem_addr", memAddr, 16'h0000);

    // Opcode-only instruction at 0x0010
    memArr[16'h0010 >> 1] = 16'h1234;
    applyStimulus(1'b1, 1'b1, 16'h0010, 1'b0, 1'b0);
    checkOutput("flush_pc_op", 16'(pcOp), 16'(PC_SET));
    checkOutput("flush_pc_target", pcTarget, 16'h0010);
    tick();
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
    checkOutput("noimm_mem_addr", memAddr, 16'h0010);
    checkOutput("noimm_pc_op", 16'(pcOp), 16'(PC_INC));
    tick();
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    checkOutput("noimm_valid", 16'(instrValid), 16'd1);
    checkOutput("noimm_word", instrWord, 16'h1234);
    checkOutput("noimm_has_imm", 16'(hasImm), 16'd0);
    checkOutput("noimm_imm", immWord, 16'h0000);
    checkOutput("noimm_pc", pcReg, 16'h0012);
    checkOutput("noimm_pc_target", pcTarget, 16'h0000);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    checkOutput("after_hs_valid", 16'(instrValid), 16'd0);
    checkOutput("after_hs_mem_addr", memAddr, 16'h0012);

    // Immediate instruction at 0x0010
    memArr[16'h0010 >> 1] = 16'h0100;
    memArr[16'h0012 >> 1] = 16'hBEEF;
    applyStimulus(1'b1, 1'b1, 16'h0010, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    checkOutput("imm_second_addr", memAddr, 16'h0012);
    checkOutput("imm_mid_valid", 16'(instrValid), 16'd0);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    checkOutput("imm_valid", 16'(instrValid), 16'd1);
    checkOutput("imm_word", immWord, 16'hBEEF);
    checkOutput("imm_has_imm", 16'(hasImm), 16'd1);
    checkOutput("imm_instr_word", instrWord, 16'h0100);
    checkOutput("imm_pc", pcReg, 16'h0014);

    // Backpressure from the decoder
    for (int i = 0; i < 3; i++) begin
      tick();
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
      checkOutput("bp_valid", 16'(instrValid), 16'd1);
      checkOutput("bp_imm", immWord, 16'hBEEF);
      checkOutput("bp_mem_req", 16'(memReq), 16'd0);
      checkOutput("bp_pc_op", 16'(pcOp), 16'(PC_NOP));
      checkOutput("bp_pc", pcReg, 16'h0014);
    end
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    checkOutput("bp_resume_req", 16'(memReq), 16'd1);
    checkOutput("bp_resume_addr", memAddr, 16'h0014);

    // Flush while fetching the immediate, with a colliding ack
    memArr[16'h0014 >> 1] = 16'h0100;
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 16'h0200, 1'b1, 1'b1);
    checkOutput("flimm_pc_op", 16'(pcOp), 16'(PC_SET));
    checkOutput("flimm_target", pcTarget, 16'h0200);
    checkOutput("flimm_mem_req", 16'(memReq), 16'd0);
    checkOutput("flimm_valid", 16'(instrValid), 16'd0);
    tick();
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
    checkOutput("flimm_next_addr", memAddr, 16'h0200);
    checkOutput("flimm_next_valid", 16'(instrValid), 16'd0);

    // Stall with spurious acks
    memArr[16'h0200 >> 1] = 16'h00AA;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
      checkOutput("stall_mem_req", 16'(memReq), 16'd0);
      checkOutput("stall_pc_op", 16'(pcOp), 16'(PC_NOP));
      checkOutput("stall_pc", pcReg, 16'h0200);
      tick();
    end
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    checkOutput("stall_resume_req", 16'(memReq), 16'd1);
    checkOutput("stall_resume_addr", memAddr, 16'h0200);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
    checkOutput("stall_instr", instrWord, 16'h00AA);
    checkOutput("stall_instr_pc", pcReg, 16'h0202);
    tick();

    // PC wrap across the top of memory
    memArr[16'hFFFE >> 1] = 16'h0155;
    memArr[0] = 16'h4321;
    applyStimulus(1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
    checkOutput("wrap_first_addr", memAddr, 16'hFFFE);
    tick();
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    checkOutput("wrap_second_addr", memAddr, 16'h0000);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    checkOutput("wrap_instr", instrWord, 16'h0155);
    checkOutput("wrap_imm", immWord, 16'h4321);
    checkOutput("wrap_pc", pcReg, 16'h0002);

    // Randomized run: every accepted instruction must be the next one in program order
    expAddr = 16'($urandom) & 16'hFFFE;
    applyStimulus(1'b1, 1'b1, expAddr, 1'b0, 1'b0);
    tick();
    accepted = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic        enR, flR, ackR, rdyR;
      logic [15:0] faR;
      enR  = ($urandom % 8) != 0;
      flR  = ($urandom % 60) == 0;
      ackR = $urandom % 2;
      rdyR = ($urandom % 3) != 0;
      faR  = 16'($urandom) & 16'hFFFE;
      applyStimulus(enR, flR, faR, ackR, rdyR);
      if (memReq) checkOutput("rand_mem_addr", memAddr, pcReg);
      if (flR) begin
        expAddr = faR;
      end else if (enR && instrValid && rdyR) begin
        op = memArr[expAddr[15:1]];
        accepted++;
        checkOutput("rand_instr", instrWord, op);
        checkOutput("rand_has_imm", 16'(hasImm), 16'(op[8]));
        if (op[8]) begin
          checkOutput("rand_imm", immWord, memArr[16'(expAddr + 16'd2) >> 1]);
          expAddr = expAddr + 16'd4;
        end else begin
          checkOutput("rand_imm", immWord, 16'h0000);
          expAddr = expAddr + 16'd2;
        end
      end
      tick();
    end
    checkOutput("rand_progress", 16'(accepted > 50), 16'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
